// File: rtl/dm_bus_bridge_pkg.sv
// Shared encodings for the data-memory bus bridge: FSM states, store-size and load-type codes.
// Pure declarations, no logic and no latency.
// No flow control here; the codes are shared with the multicycle controller so both agree on values.
package dm_bus_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Store size codes (cpu_wrbits); 2'b11 is reserved and behaves as a word store
    localparam logic [1:0] WR_SW  = 2'b00;
    localparam logic [1:0] WR_SH  = 2'b01;
    localparam logic [1:0] WR_SB  = 2'b10;
    localparam logic [1:0] WR_RSV = 2'b11;

    // Load type codes (cpu_rbits); any other code behaves as a word load
    localparam logic [2:0] RD_LW  = 3'b000;
    localparam logic [2:0] RD_LH  = 3'b001;
    localparam logic [2:0] RD_LHU = 3'b010;
    localparam logic [2:0] RD_LB  = 3'b011;
    localparam logic [2:0] RD_LBU = 3'b100;

    // Timeout counter width: just wide enough for the limit, clamped to 8..16 bits
    function automatic int tmo_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8) begin
            w = 8;
        end
        if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/dm_bus_bridge_if.sv
// CPU-side data-memory port plus the external req/ack word bus, bundled for the bridge.
// Wires only, no latency.
// master = bridge view (drives bus and CPU responses); slave = CPU plus memory view.
interface dm_bus_bridge_if #(
    parameter int ADDR_W = 32
) ();

    // CPU data-memory access point
    logic              cpu_rd;
    logic              cpu_wr;
    logic [1:0]        cpu_wrbits;
    logic [2:0]        cpu_rbits;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              cpu_err;

    // External wait-stated word bus
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        input  cpu_rd, cpu_wr, cpu_wrbits, cpu_rbits, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall, cpu_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_wrbits, cpu_rbits, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall, cpu_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/dm_bus_bridge_lane_align.sv
// Byte-lane steering: byte enables, write-lane replication, misalignment check, load extract/extend.
// Purely combinational, zero latency.
// No flow control; request-side and response-side operands are independent inputs.
module dm_lane_align
    import dm_bus_bridge_pkg::*;
(
    // Request side (live CPU request)
    input  logic [1:0]  req_addr_lo_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_wrbits_i,
    input  logic [2:0]  req_rbits_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    output logic        req_misalign_o,
    // Response side (captured request + bus read word)
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic [2:0]  rsp_rbits_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte enables, replicated store data and alignment check for the incoming request
    always_comb begin
        req_be_o       = 4'b1111;
        req_wdata_o    = req_wdata_i;
        req_misalign_o = 1'b0;
        if (req_we_i) begin
            case (req_wrbits_i)
                WR_SH: begin
                    req_be_o       = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    req_wdata_o    = {2{req_wdata_i[15:0]}};
                    req_misalign_o = req_addr_lo_i[0];
                end
                WR_SB: begin
                    req_be_o    = 4'b0001 << req_addr_lo_i;
                    req_wdata_o = {4{req_wdata_i[7:0]}};
                end
                default: begin
                    // sw and the reserved code both move a full word
                    req_misalign_o = (req_addr_lo_i != 2'b00);
                end
            endcase
        end else begin
            case (req_rbits_i)
                RD_LH, RD_LHU: req_misalign_o = req_addr_lo_i[0];
                RD_LB, RD_LBU: req_misalign_o = 1'b0;
                default:       req_misalign_o = (req_addr_lo_i != 2'b00);
            endcase
        end
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits
    always_comb begin
        case (rsp_addr_lo_i)
            2'd0:    byte_sel = rsp_rdata_i[7:0];
            2'd1:    byte_sel = rsp_rdata_i[15:8];
            2'd2:    byte_sel = rsp_rdata_i[23:16];
            default: byte_sel = rsp_rdata_i[31:24];
        endcase
        half_sel = rsp_addr_lo_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];
        case (rsp_rbits_i)
            RD_LH:   rsp_rdata_o = {{16{half_sel[15]}}, half_sel};
            RD_LHU:  rsp_rdata_o = {16'h0000, half_sel};
            RD_LB:   rsp_rdata_o = {{24{byte_sel[7]}}, byte_sel};
            RD_LBU:  rsp_rdata_o = {24'h000000, byte_sel};
            default: rsp_rdata_o = rsp_rdata_i;
        endcase
    end

endmodule

// File: rtl/dm_bus_bridge.sv
// Bridges CPU byte/half/word loads and stores onto a req/ack word bus; optional macro DM_BUS_TIMEOUT_EN.
// Latency: request seen in IDLE -> bus_req next cycle -> DONE the cycle after ack (min 2 cycles).
// Backpressure: cpu_stall holds the CPU while a request waits for bus_ack; DONE always drops to IDLE.
module dm_bus_bridge
    import dm_bus_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    dm_bus_bridge_if.master bif
);

    state_e            state_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [31:0]       bus_wdata_q;
    logic [31:0]       cpu_rdata_q;
    logic              cpu_err_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        rbits_q;
    logic              conflict_q;

    logic              cpu_req_d;
    logic [ADDR_W-1:0] word_addr_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic              misalign_d;
    logic [31:0]       rdata_ext_d;
    logic              cpu_stall_d;

`ifdef DM_BUS_TIMEOUT_EN
    localparam int               TMO_W    = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]            tmo_cnt_q;
`endif

    assign cpu_req_d   = bif.cpu_rd | bif.cpu_wr;
    assign word_addr_d = {bif.cpu_addr[ADDR_W-1:2], 2'b00};

    // A simultaneous rd+wr is steered as a store (cpu_wr alone selects the store path)
    dm_lane_align u_lane_align (
        .req_addr_lo_i  (bif.cpu_addr[1:0]),
        .req_we_i       (bif.cpu_wr),
        .req_wrbits_i   (bif.cpu_wrbits),
        .req_rbits_i    (bif.cpu_rbits),
        .req_wdata_i    (bif.cpu_wdata),
        .req_be_o       (be_d),
        .req_wdata_o    (wdata_d),
        .req_misalign_o (misalign_d),
        .rsp_addr_lo_i  (addr_lo_q),
        .rsp_rbits_i    (rbits_q),
        .rsp_rdata_i    (bif.bus_rdata),
        .rsp_rdata_o    (rdata_ext_d)
    );

    // Stall follows the raw request in IDLE so the CPU freezes in the same cycle it asks
    always_comb begin
        cpu_stall_d = 1'b0;
        case (state_q)
            ST_IDLE: cpu_stall_d = cpu_req_d;
            ST_REQ:  cpu_stall_d = 1'b1;
            default: cpu_stall_d = 1'b0;
        endcase
    end

    // Bridge FSM with registered bus and CPU response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            cpu_rdata_q <= 32'h0;
            cpu_err_q   <= 1'b0;
            addr_lo_q   <= 2'b00;
            rbits_q     <= RD_LW;
            conflict_q  <= 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            cpu_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_d) begin
                        addr_lo_q  <= bif.cpu_addr[1:0];
                        rbits_q    <= bif.cpu_rbits;
                        conflict_q <= bif.cpu_rd & bif.cpu_wr;
                        if (misalign_d) begin
                            // No bus traffic: report the error straight away
                            state_q     <= ST_DONE;
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= ST_REQ;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= bif.cpu_wr;
                            bus_addr_q  <= word_addr_d;
                            bus_be_q    <= be_d;
                            bus_wdata_q <= bif.cpu_wr ? wdata_d : 32'h0;
`ifdef DM_BUS_TIMEOUT_EN
                            tmo_cnt_q   <= '0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (bif.bus_ack) begin
                        bus_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        cpu_err_q <= conflict_q;
                        if (!bus_we_q) begin
                            cpu_rdata_q <= rdata_ext_d;
                        end
                    end
`ifdef DM_BUS_TIMEOUT_EN
                    // Ack in the final allowed cycle wins over the timeout
                    else if (tmo_cnt_q == TMO_LAST) begin
                        bus_req_q   <= 1'b0;
                        state_q     <= ST_DONE;
                        cpu_err_q   <= 1'b1;
                        cpu_rdata_q <= 32'h0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    // One-cycle completion window; a held request restarts from IDLE
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bif.bus_req   = bus_req_q;
    assign bif.bus_we    = bus_we_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_be    = bus_be_q;
    assign bif.bus_wdata = bus_wdata_q;
    assign bif.cpu_rdata = cpu_rdata_q;
    assign bif.cpu_err   = cpu_err_q;
    assign bif.cpu_stall = cpu_stall_d;

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
- Sits between the multicycle datapath's data-memory access point and an external wait-stated word bus.
- Converts a byte/half/word load or store into one req/ack bus transaction, and stalls the multicycle controller until the transaction completes.
- Generates byte enables and write-lane replication, and sign/zero-extends load data.
- Little-endian byte lanes.

Parameters:
- ADDR_W, 32, CPU and bus address width.
- TIMEOUT_CYCLES, 255, wait limit for bus_ack; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  load request, level; held by CPU while cpu_stall=1.
- cpu_wr  in  1  store request, level; held by CPU while cpu_stall=1.
- cpu_wrbits  in  2  store size: 00 sw, 01 sh, 10 sb, 11 reserved (treated as sw).
- cpu_rbits  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others treated as lw.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_rdata  out  32  extended load data; valid in DONE state.
- cpu_stall  out  1  1 while a request is pending and not yet complete.
- cpu_err  out  1  one-cycle pulse in DONE for misalignment, rd+wr conflict or timeout.
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address; bits [1:0] are 00.
- bus_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- bus_wdata  out  32  lane-replicated write data.
- bus_ack  in  1  slave completion; read data valid in the same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, cpu_rdata and cpu_err are all 0.
  - An in-flight bus transaction is abandoned; bus_req drops immediately.
- States: IDLE, REQ, DONE.
- IDLE:
  - cpu_stall = cpu_rd|cpu_wr (combinational).
  - When a request is present, capture address, size, type and data on the clock edge.
  - Aligned request: go to REQ with bus_req=1 from the next cycle.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=00): no bus transaction; go to DONE with cpu_err=1 and cpu_rdata=0.
- rd+wr asserted together: treated as a store, and cpu_err=1 in DONE.
- REQ:
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable.
  - cpu_stall=1.
  - On a clock edge with bus_ack=1: latch the extended bus_rdata (reads only), drop bus_req, go to DONE.
  - bus_ack outside REQ is ignored.
- DONE:
  - Lasts exactly one cycle; cpu_stall=0 and cpu_rdata is valid.
  - Always returns to IDLE, even if the CPU still asserts its request.
  - A held request therefore starts a new access one cycle later; back-to-back accesses cost at least 3 cycles each.
- Minimum aligned latency: request seen in IDLE at cycle 0, bus_req high at cycle 1, ack at cycle 1 gives DONE at cycle 2.
- Store lanes:
  - sw: be=1111, wdata=cpu_wdata.
  - sh: be=0011 if addr[1]=0, else 1100; wdata={2{cpu_wdata[15:0]}}.
  - sb: be=0001<<addr[1:0]; wdata={4{cpu_wdata[7:0]}}.
- Loads:
  - bus_be=1111 for all loads.
  - lw returns the full word.
  - lh/lhu select the halfword by addr[1]; lb/lbu select the byte by addr[1:0].
  - lh and lb sign-extend; lhu and lbu zero-extend.
- cpu_rdata holds its value after DONE until the next completed read.

Optional Feature:
- Macro: DM_BUS_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter, sized to TIMEOUT_CYCLES, clears on entry to REQ and counts each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop bus_req, go to DONE with cpu_err=1 and cpu_rdata=0.
  - bus_ack arriving in that same cycle takes priority over the timeout.
- Not defined: no counter; REQ waits indefinitely for bus_ack.

Decomposition:
- Shared package/header (ctrl_encode_def):
  - state encodings IDLE=2'd0, REQ=2'd1, DONE=2'd2.
  - cpu_wrbits codes and cpu_rbits codes, shared with Control so both use the same values.
- Sub-module dm_lane_align (combinational), containing:
  - byte-enable generation
  - write-lane replication
  - read byte/half selection and extension
  - misalignment detection
- The top module keeps the FSM, the capture registers and the timeout counter.

Test Plan:
- lw at addr 0x10, bus_ack after 3 wait cycles, bus_rdata=0xDEADBEEF -> bus_addr=0x10, be=1111; cpu_stall high 5 cycles; cpu_rdata=0xDEADBEEF in DONE; cpu_err=0.
- sb cpu_wdata=0x000000A5, addr 0x23, immediate ack -> be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x20, bus_we=1.
- lb addr 0x22, bus_rdata=0x0080FF00 -> cpu_rdata=0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x22 -> 0x00000080.
- sh addr 0x31 -> no bus_req; DONE next cycle with cpu_err=1 and cpu_rdata=0.
- rst pulled low while in REQ with bus_req=1 -> bus_req=0 asynchronously; after release, state is IDLE and outputs are 0.
- DM_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> bus_req drops after 4 REQ cycles; cpu_err=1 for one cycle.
